order_issue_queue: RTL and testbench
====================================

ORDER_ISSUE_QUEUE -- requirements
Module: order_issue_queue

Interface
REQ-001 Parameter RS_SIZE, default 8, entry count; legal range max(DISPATCH_WIDTH,ISSUE_WIDTH) <= RS_SIZE, power of two not required.
REQ-002 Parameter DISPATCH_WIDTH, default 2, dispatch lanes per cycle.
REQ-003 Parameter ISSUE_WIDTH, default 2, in-order issue ports per cycle.
REQ-004 Parameter OPTION_CODE, default OptionCodeSt, type of per-entry option code.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 flush_i  input  1  synchronous flush; empties the queue.
REQ-008 rs_base_i  input  DISPATCH_WIDTH x RsBaseSt  dispatch payload per lane.
REQ-009 option_code_i  input  DISPATCH_WIDTH x OPTION_CODE  option code per lane.
REQ-010 wr_valid_i  input  DISPATCH_WIDTH  per-lane dispatch valid; any bit pattern is legal.
REQ-011 wr_ready_o  output  1  queue accepts all valid lanes this cycle.
REQ-012 wb_pdest_valid_i  input  `WB_WIDTH  writeback valid per port.
REQ-013 wb_pdest_i  input  `WB_WIDTH x $clog2(`PHY_REG_NUM)  writeback physical tag per port.
REQ-014 issue_valid_o  output  ISSUE_WIDTH  issue port k holds an issuable entry.
REQ-015 issue_ready_i  input  ISSUE_WIDTH  consumer accepts port k.
REQ-016 issue_base_o  output  ISSUE_WIDTH x IssueBaseSt  rs2is() of the entry on port k.
REQ-017 issue_oc_o  output  ISSUE_WIDTH x OPTION_CODE  option code of the entry on port k.
REQ-018 count_o  output  $clog2(RS_SIZE)+1  registered occupancy.

Function
REQ-019 Storage is a circular FIFO with registered read pointer, write pointer and count; pointers wrap from RS_SIZE-1 to 0 for any RS_SIZE.
REQ-020 wr_ready_o = (RS_SIZE - count_q) >= DISPATCH_WIDTH, from registered state only; it is independent of same-cycle issue.
REQ-021 When wr_ready_o is high, valid lanes are written to consecutive slots from write pointer in ascending lane order, skipping invalid lanes; write pointer and count advance by popcount(wr_valid_i).
REQ-022 When wr_ready_o is low, no lane is written: all-or-nothing dispatch.
REQ-023 A dispatched entry sets psrcN_ready if its incoming psrcN_ready is set or psrcN matches any valid wb_pdest_i in the same cycle.
REQ-024 Every cycle, for each occupied entry and each valid writeback port, a tag match on psrc0/psrc1 sets the corresponding ready bit in the next state.
REQ-025 Entry at offset k from read pointer is operand-ready when (psrc0_ready | ~psrc0_valid) & (psrc1_ready | ~psrc1_valid).
REQ-026 issue_valid_o[k] = (k < count_q) & operand-ready(k) & issue_valid_o[k-1] (k=0 has no predecessor term); strict program order, no bypass of a stalled older entry.
REQ-027 Pop count P = number of leading ports k=0,1,... with issue_valid_o[k] & issue_ready_i[k]; first port failing the handshake stops popping, later handshakes are ignored.
REQ-028 Popped entries are invalidated; read pointer advances by P with wrap.
REQ-029 count_n = count_q + pushes - pops; simultaneous push and pop are both honoured.
REQ-030 Outputs on ports with issue_valid_o[k]=0 are don't-care but must be deterministic (entry contents at offset k).
REQ-031 flush_i high: next cycle pointers=0, count=0, all entries invalid; dispatch, wakeup and pop in the flush cycle are discarded.
REQ-032 Latency: a dispatched entry with ready operands is issuable the cycle after dispatch; wakeup-to-issue is one cycle (see REQ-036).

Reset
REQ-033 rst_n low asynchronously clears pointers, count and every entry valid/ready bit; entry payload need not be reset.
REQ-034 During and after reset until first dispatch: wr_ready_o=1, issue_valid_o=0, count_o=0.
REQ-035 Reset asserted mid-operation discards all entries with no partial issue.

Configuration
REQ-036 Macro ORDER_IQ_WAKEUP_BYPASS_EN: when defined, operand-ready in REQ-025 also ORs same-cycle wb_pdest_i matches, giving zero-cycle wakeup-to-issue; when undefined, only registered ready bits are used (one-cycle wakeup-to-issue). Dispatch capture (REQ-023) is present in both builds.

Verification
REQ-037 Reset, dispatch lanes 0,1 ready operands -> next cycle issue_valid_o=2'b11, both ready -> count_o 2->0.
REQ-038 Fill 8 entries -> wr_ready_o=0 at count 7 and 8; dispatch while low -> no state change.
REQ-039 Head waits on psrc0=5, entry1 ready -> issue_valid_o=2'b00; wb tag 5 -> next cycle 2'b11 (same cycle with ORDER_IQ_WAKEUP_BYPASS_EN).
REQ-040 issue_ready_i=2'b10 with issue_valid_o=2'b11 -> no pop, count unchanged.
REQ-041 wr_valid_i=2'b10 with wb tag matching its psrc1 same cycle -> entry stored ready, issues next cycle; RS_SIZE=6 wrap of pointers 5->0 correct.
REQ-042 flush_i with count 5 and simultaneous dispatch/pop -> next cycle count_o=0, issue_valid_o=0.

Source files
------------

// File: rtl/order_issue_queue.sv
// In-order issue queue: circular FIFO reservation station with per-operand tag wakeup.
// Build macro ORDER_IQ_WAKEUP_BYPASS_EN adds same-cycle writeback-to-issue bypass.

`ifndef WB_WIDTH
`define WB_WIDTH 2
`endif
`ifndef PHY_REG_NUM
`define PHY_REG_NUM 64
`endif

package order_iq_pkg;
    localparam int PREG_W = $clog2(`PHY_REG_NUM);
    typedef logic [PREG_W-1:0] PhyRegT;

    typedef struct packed {
        logic [15:0] imm;
        PhyRegT      pdest;
        logic        pdest_valid;
        PhyRegT      psrc0;
        logic        psrc0_valid;
        logic        psrc0_ready;
        PhyRegT      psrc1;
        logic        psrc1_valid;
        logic        psrc1_ready;
    } RsBaseSt;

    typedef struct packed {
        logic [15:0] imm;
        PhyRegT      pdest;
        logic        pdest_valid;
        PhyRegT      psrc0;
        logic        psrc0_valid;
        PhyRegT      psrc1;
        logic        psrc1_valid;
    } IssueBaseSt;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] fu;
    } OptionCodeSt;

    function automatic IssueBaseSt rs2is(input RsBaseSt rs);
        IssueBaseSt is;
        is.imm         = rs.imm;
        is.pdest       = rs.pdest;
        is.pdest_valid = rs.pdest_valid;
        is.psrc0       = rs.psrc0;
        is.psrc0_valid = rs.psrc0_valid;
        is.psrc1       = rs.psrc1;
        is.psrc1_valid = rs.psrc1_valid;
        return is;
    endfunction
endpackage

module order_issue_queue
    import order_iq_pkg::*;
#(
    parameter int  RS_SIZE        = 8,
    parameter int  DISPATCH_WIDTH = 2,
    parameter int  ISSUE_WIDTH    = 2,
    parameter type OPTION_CODE    = OptionCodeSt
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  RsBaseSt                   rs_base_i     [DISPATCH_WIDTH],
    input  OPTION_CODE                option_code_i [DISPATCH_WIDTH],
    input  logic [DISPATCH_WIDTH-1:0] wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [`WB_WIDTH-1:0]      wb_pdest_valid_i,
    input  PhyRegT                    wb_pdest_i    [`WB_WIDTH],
    output logic [ISSUE_WIDTH-1:0]    issue_valid_o,
    input  logic [ISSUE_WIDTH-1:0]    issue_ready_i,
    output IssueBaseSt                issue_base_o  [ISSUE_WIDTH],
    output OPTION_CODE                issue_oc_o    [ISSUE_WIDTH],
    output logic [$clog2(RS_SIZE):0]  count_o
);
    localparam int PTR_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CNT_W = $clog2(RS_SIZE) + 1;

    typedef logic [PTR_W-1:0] PtrT;
    typedef logic [CNT_W-1:0] CntT;

    // Pointer increment with explicit wrap so non-power-of-two sizes work.
    function automatic PtrT wrapAdd(input PtrT ptr, input int inc);
        int sum;
        sum = int'(ptr) + inc;
        if (sum >= RS_SIZE) sum = sum - RS_SIZE;
        return PtrT'(sum);
    endfunction

    function automatic logic wbHit(input PhyRegT tag);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < `WB_WIDTH; p++)
            if (wb_pdest_valid_i[p] && (wb_pdest_i[p] == tag)) hit = 1'b1;
        return hit;
    endfunction

    IssueBaseSt         entry_q [RS_SIZE];
    IssueBaseSt         entry_d [RS_SIZE];
    OPTION_CODE         oc_q    [RS_SIZE];
    OPTION_CODE         oc_d    [RS_SIZE];
    logic [RS_SIZE-1:0] valid_q, valid_d, rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    PtrT                rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    CntT                count_q, count_d;

    PtrT                issueIdx [ISSUE_WIDTH];
    logic               src0Ok, src1Ok, prevValid, popStop;
    int                 popCnt, pushCnt;
    PtrT                slot;

    assign wr_ready_o = (int'(count_q) + DISPATCH_WIDTH) <= RS_SIZE;
    assign count_o    = count_q;

    // Issue ports walk from the head in program order; a stalled entry blocks all younger ones.
    always_comb begin
        popCnt    = 0;
        popStop   = 1'b0;
        prevValid = 1'b1;
        src0Ok    = 1'b0;
        src1Ok    = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            issueIdx[k] = wrapAdd(rdPtr_q, k);
            src0Ok = rdy0_q[issueIdx[k]] | ~entry_q[issueIdx[k]].psrc0_valid;
            src1Ok = rdy1_q[issueIdx[k]] | ~entry_q[issueIdx[k]].psrc1_valid;
`ifdef ORDER_IQ_WAKEUP_BYPASS_EN
            src0Ok = src0Ok | wbHit(entry_q[issueIdx[k]].psrc0);
            src1Ok = src1Ok | wbHit(entry_q[issueIdx[k]].psrc1);
`endif
            issue_valid_o[k] = (k < int'(count_q)) && src0Ok && src1Ok && prevValid;
            prevValid        = issue_valid_o[k];
            issue_base_o[k]  = entry_q[issueIdx[k]];
            issue_oc_o[k]    = oc_q[issueIdx[k]];
            if (!popStop && issue_valid_o[k] && issue_ready_i[k]) popCnt = popCnt + 1;
            else popStop = 1'b1;
        end
    end

    // Next state: wakeup, pop, then all-or-nothing dispatch; flush overrides everything.
    always_comb begin
        entry_d = entry_q;
        oc_d    = oc_q;
        valid_d = valid_q;
        rdy0_d  = rdy0_q;
        rdy1_d  = rdy1_q;
        pushCnt = 0;
        slot    = wrPtr_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i] && wbHit(entry_q[i].psrc0)) rdy0_d[i] = 1'b1;
            if (valid_q[i] && wbHit(entry_q[i].psrc1)) rdy1_d[i] = 1'b1;
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (k < popCnt) begin
                valid_d[issueIdx[k]] = 1'b0;
                rdy0_d[issueIdx[k]]  = 1'b0;
                rdy1_d[issueIdx[k]]  = 1'b0;
            end
        end
        if (wr_ready_o) begin
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                if (wr_valid_i[l]) begin
                    entry_d[slot] = rs2is(rs_base_i[l]);
                    oc_d[slot]    = option_code_i[l];
                    valid_d[slot] = 1'b1;
                    rdy0_d[slot]  = rs_base_i[l].psrc0_ready | wbHit(rs_base_i[l].psrc0);
                    rdy1_d[slot]  = rs_base_i[l].psrc1_ready | wbHit(rs_base_i[l].psrc1);
                    slot          = wrapAdd(slot, 1);
                    pushCnt       = pushCnt + 1;
                end
            end
        end
        rdPtr_d = wrapAdd(rdPtr_q, popCnt);
        wrPtr_d = slot;
        count_d = count_q + CntT'(pushCnt) - CntT'(popCnt);
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
            valid_d = '0;
            rdy0_d  = '0;
            rdy1_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            valid_q <= '0;
            rdy0_q  <= '0;
            rdy1_q  <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
        end
    end

    // Payload is qualified by the valid/ready bits, so it carries no reset.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
        oc_q    <= oc_d;
    end
endmodule

// File: tb/tb_order_issue_queue.sv
// Directed bench for order_issue_queue: an RS_SIZE=8 instance for the main scenarios and an
// RS_SIZE=6 instance for non-power-of-two pointer wrap.

`ifndef WB_WIDTH
`define WB_WIDTH 2
`endif
`ifndef PHY_REG_NUM
`define PHY_REG_NUM 64
`endif

module tb_order_issue_queue;
    import order_iq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        flush8, flush6;
    RsBaseSt     base8 [2];
    RsBaseSt     base6 [2];
    OptionCodeSt oc8 [2];
    OptionCodeSt oc6 [2];
    logic [1:0]  wrValid8, wrValid6;
    logic        wrReady8, wrReady6;
    logic [`WB_WIDTH-1:0] wbValid8, wbValid6;
    PhyRegT      wbTag8 [`WB_WIDTH];
    PhyRegT      wbTag6 [`WB_WIDTH];
    logic [1:0]  issueValid8, issueValid6, issueReady8, issueReady6;
    IssueBaseSt  issueBase8 [2];
    IssueBaseSt  issueBase6 [2];
    OptionCodeSt issueOc8 [2];
    OptionCodeSt issueOc6 [2];
    logic [3:0]  count8, count6;

    int total = 0;
    int bad   = 0;
    logic [1:0] expSame;

    always #5 clk = ~clk;

    order_issue_queue #(.RS_SIZE(8), .DISPATCH_WIDTH(2), .ISSUE_WIDTH(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush8),
        .rs_base_i(base8), .option_code_i(oc8), .wr_valid_i(wrValid8), .wr_ready_o(wrReady8),
        .wb_pdest_valid_i(wbValid8), .wb_pdest_i(wbTag8),
        .issue_valid_o(issueValid8), .issue_ready_i(issueReady8),
        .issue_base_o(issueBase8), .issue_oc_o(issueOc8), .count_o(count8)
    );

    order_issue_queue #(.RS_SIZE(6), .DISPATCH_WIDTH(2), .ISSUE_WIDTH(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush6),
        .rs_base_i(base6), .option_code_i(oc6), .wr_valid_i(wrValid6), .wr_ready_o(wrReady6),
        .wb_pdest_valid_i(wbValid6), .wb_pdest_i(wbTag6),
        .issue_valid_o(issueValid6), .issue_ready_i(issueReady6),
        .issue_base_o(issueBase6), .issue_oc_o(issueOc6), .count_o(count6)
    );

    function automatic RsBaseSt mk(input int pd, input int s0, input bit s0v, input int s1, input bit s1v);
        RsBaseSt r;
        r.imm         = 16'(pd);
        r.pdest       = PhyRegT'(pd);
        r.pdest_valid = 1'b1;
        r.psrc0       = PhyRegT'(s0);
        r.psrc0_valid = s0v;
        r.psrc0_ready = 1'b0;
        r.psrc1       = PhyRegT'(s1);
        r.psrc1_valid = s1v;
        r.psrc1_ready = 1'b0;
        return r;
    endfunction

    function automatic RsBaseSt rdy(input int pd);
        return mk(pd, 0, 1'b0, 0, 1'b0);
    endfunction

    task automatic applyStimulus(input bit sel6, input logic fl, input logic [1:0] wv,
                                 input RsBaseSt b0, input RsBaseSt b1, input logic [1:0] ir,
                                 input logic [`WB_WIDTH-1:0] wbv, input int tag);
        OptionCodeSt o0, o1;
        o0.opcode = b0.pdest[3:0];
        o0.fu     = 2'b00;
        o1.opcode = b1.pdest[3:0];
        o1.fu     = 2'b01;
        if (sel6) begin
            flush6 = fl; wrValid6 = wv; base6[0] = b0; base6[1] = b1;
            oc6[0] = o0; oc6[1] = o1; issueReady6 = ir; wbValid6 = wbv;
            for (int p = 0; p < `WB_WIDTH; p++) wbTag6[p] = PhyRegT'(tag);
        end else begin
            flush8 = fl; wrValid8 = wv; base8[0] = b0; base8[1] = b1;
            oc8[0] = o0; oc8[1] = o1; issueReady8 = ir; wbValid8 = wbv;
            for (int p = 0; p < `WB_WIDTH; p++) wbTag8[p] = PhyRegT'(tag);
        end
        #1;
    endtask

    task automatic idle(input bit sel6);
        applyStimulus(sel6, 1'b0, 2'b00, rdy(0), rdy(0), 2'b00, '0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1'b0);
        idle(1'b1);
        // Dispatch attempted while reset is held must be ignored
        applyStimulus(1'b0, 1'b0, 2'b11, rdy(1), rdy(2), 2'b00, '0, 0);
        step();
        checkOutput("rst_count", 32'(count8), 32'd0);
        checkOutput("rst_wrready", 32'(wrReady8), 32'd1);
        checkOutput("rst_ivalid", 32'(issueValid8), 32'd0);
        checkOutput("rst_count6", 32'(count6), 32'd0);
        idle(1'b0);
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_count", 32'(count8), 32'd0);

        // Two ready entries become issuable the following cycle
        applyStimulus(1'b0, 1'b0, 2'b11, rdy(10), rdy(11), 2'b00, '0, 0);
        step();
        idle(1'b0);
        checkOutput("disp_count", 32'(count8), 32'd2);
        checkOutput("disp_ivalid", 32'(issueValid8), 32'b11);
        checkOutput("disp_pdest0", 32'(issueBase8[0].pdest), 32'd10);
        checkOutput("disp_pdest1", 32'(issueBase8[1].pdest), 32'd11);
        checkOutput("disp_oc1", 32'(issueOc8[1].opcode), 32'hB);

        // Port 1 ready without port 0 must not pop
        applyStimulus(1'b0, 1'b0, 2'b00, rdy(0), rdy(0), 2'b10, '0, 0);
        step();
        idle(1'b0);
        checkOutput("noPop_count", 32'(count8), 32'd2);
        checkOutput("noPop_ivalid", 32'(issueValid8), 32'b11);

        applyStimulus(1'b0, 1'b0, 2'b00, rdy(0), rdy(0), 2'b01, '0, 0);
        step();
        idle(1'b0);
        checkOutput("pop1_count", 32'(count8), 32'd1);
        checkOutput("pop1_head", 32'(issueBase8[0].pdest), 32'd11);
        checkOutput("pop1_ivalid", 32'(issueValid8), 32'b01);

        applyStimulus(1'b0, 1'b0, 2'b00, rdy(0), rdy(0), 2'b11, '0, 0);
        step();
        idle(1'b0);
        checkOutput("drain_count", 32'(count8), 32'd0);
        checkOutput("drain_ivalid", 32'(issueValid8), 32'b00);

        // Fill to 7 and confirm dispatch is refused
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b11, rdy(20 + 2 * i), rdy(21 + 2 * i), 2'b00, '0, 0);
            step();
        end
        idle(1'b0);
        checkOutput("fill6_count", 32'(count8), 32'd6);
        checkOutput("fill6_wrready", 32'(wrReady8), 32'd1);
        applyStimulus(1'b0, 1'b0, 2'b10, rdy(27), rdy(26), 2'b00, '0, 0);
        step();
        idle(1'b0);
        checkOutput("fill7_count", 32'(count8), 32'd7);
        checkOutput("fill7_wrready", 32'(wrReady8), 32'd0);
        checkOutput("fill7_head", 32'(issueBase8[0].pdest), 32'd20);
        applyStimulus(1'b0, 1'b0, 2'b11, rdy(30), rdy(31), 2'b00, '0, 0);
        step();
        idle(1'b0);
        checkOutput("blocked7_count", 32'(count8), 32'd7);
        checkOutput("blocked7_head", 32'(issueBase8[0].pdest), 32'd20);

        applyStimulus(1'b0, 1'b0, 2'b00, rdy(0), rdy(0), 2'b11, '0, 0);
        step();
        idle(1'b0);
        checkOutput("pop2_count", 32'(count8), 32'd5);
        checkOutput("pop2_head", 32'(issueBase8[0].pdest), 32'd22);

        // Flush wins over simultaneous dispatch and pop
        applyStimulus(1'b0, 1'b1, 2'b11, rdy(40), rdy(41), 2'b11, '0, 0);
        step();
        idle(1'b0);
        checkOutput("flush_count", 32'(count8), 32'd0);
        checkOutput("flush_ivalid", 32'(issueValid8), 32'b00);
        checkOutput("flush_wrready", 32'(wrReady8), 32'd1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b11, rdy(50 + 2 * i), rdy(51 + 2 * i), 2'b00, '0, 0);
            step();
        end
        idle(1'b0);
        checkOutput("full_count", 32'(count8), 32'd8);
        checkOutput("full_wrready", 32'(wrReady8), 32'd0);
        checkOutput("full_head", 32'(issueBase8[0].pdest), 32'd50);
        applyStimulus(1'b0, 1'b0, 2'b11, rdy(58), rdy(59), 2'b00, '0, 0);
        step();
        idle(1'b0);
        checkOutput("blocked8_count", 32'(count8), 32'd8);
        applyStimulus(1'b0, 1'b1, 2'b00, rdy(0), rdy(0), 2'b00, '0, 0);
        step();
        idle(1'b0);
        checkOutput("flush2_count", 32'(count8), 32'd0);

        // Head waits on tag 5 and blocks the ready younger entry
        applyStimulus(1'b0, 1'b0, 2'b11, mk(60, 5, 1'b1, 0, 1'b0), rdy(61), 2'b00, '0, 0);
        step();
        idle(1'b0);
        checkOutput("wait_ivalid", 32'(issueValid8), 32'b00);
        checkOutput("wait_count", 32'(count8), 32'd2);
        applyStimulus(1'b0, 1'b0, 2'b00, rdy(0), rdy(0), 2'b00, 2'b10, 6);
        step();
        idle(1'b0);
        checkOutput("wrongTag_ivalid", 32'(issueValid8), 32'b00);
        applyStimulus(1'b0, 1'b0, 2'b00, rdy(0), rdy(0), 2'b00, 2'b01, 5);
`ifdef ORDER_IQ_WAKEUP_BYPASS_EN
        expSame = 2'b11;
`else
        expSame = 2'b00;
`endif
        checkOutput("wake_same_ivalid", 32'(issueValid8), 32'(expSame));
        step();
        idle(1'b0);
        checkOutput("wake_next_ivalid", 32'(issueValid8), 32'b11);
        checkOutput("wake_head", 32'(issueBase8[0].pdest), 32'd60);
        applyStimulus(1'b0, 1'b0, 2'b00, rdy(0), rdy(0), 2'b11, '0, 0);
        step();
        idle(1'b0);
        checkOutput("wake_drain", 32'(count8), 32'd0);

        // Lane 1 only, with its psrc1 tag written back in the dispatch cycle
        applyStimulus(1'b0, 1'b0, 2'b10, rdy(1), mk(45, 0, 1'b0, 9, 1'b1), 2'b00, 2'b01, 9);
        step();
        idle(1'b0);
        checkOutput("capt_count", 32'(count8), 32'd1);
        checkOutput("capt_ivalid", 32'(issueValid8), 32'b01);
        checkOutput("capt_pdest", 32'(issueBase8[0].pdest), 32'd45);
        applyStimulus(1'b0, 1'b0, 2'b00, rdy(0), rdy(0), 2'b01, '0, 0);
        step();
        idle(1'b0);
        checkOutput("capt_drain", 32'(count8), 32'd0);

        // Stored entry woken later through writeback port 1
        applyStimulus(1'b0, 1'b0, 2'b01, mk(46, 0, 1'b0, 12, 1'b1), rdy(2), 2'b00, '0, 0);
        step();
        idle(1'b0);
        checkOutput("stored_wait", 32'(issueValid8), 32'b00);
        applyStimulus(1'b0, 1'b0, 2'b00, rdy(0), rdy(0), 2'b00, 2'b10, 12);
        step();
        idle(1'b0);
        checkOutput("stored_wake", 32'(issueValid8), 32'b01);
        applyStimulus(1'b0, 1'b0, 2'b00, rdy(0), rdy(0), 2'b01, '0, 0);
        step();
        idle(1'b0);
        checkOutput("stored_drain", 32'(count8), 32'd0);

        // RS_SIZE=6: pointers wrap from slot 5 back to slot 0
        applyStimulus(1'b1, 1'b0, 2'b11, rdy(1), rdy(2), 2'b00, '0, 0);
        step();
        applyStimulus(1'b1, 1'b0, 2'b11, rdy(3), rdy(4), 2'b00, '0, 0);
        step();
        idle(1'b1);
        checkOutput("w6_count4", 32'(count6), 32'd4);
        checkOutput("w6_wrready4", 32'(wrReady6), 32'd1);
        checkOutput("w6_head1", 32'(issueBase6[0].pdest), 32'd1);
        applyStimulus(1'b1, 1'b0, 2'b11, rdy(5), rdy(6), 2'b11, '0, 0);
        step();
        idle(1'b1);
        checkOutput("w6_count_c", 32'(count6), 32'd4);
        checkOutput("w6_head3", 32'(issueBase6[0].pdest), 32'd3);
        applyStimulus(1'b1, 1'b0, 2'b10, rdy(8), mk(7, 0, 1'b0, 9, 1'b1), 2'b11, 2'b01, 9);
        step();
        idle(1'b1);
        checkOutput("w6_count_d", 32'(count6), 32'd3);
        checkOutput("w6_head5", 32'(issueBase6[0].pdest), 32'd5);
        checkOutput("w6_ivalid_d", 32'(issueValid6), 32'b11);
        applyStimulus(1'b1, 1'b0, 2'b00, rdy(0), rdy(0), 2'b11, '0, 0);
        step();
        idle(1'b1);
        checkOutput("w6_count_e", 32'(count6), 32'd1);
        checkOutput("w6_head7", 32'(issueBase6[0].pdest), 32'd7);
        checkOutput("w6_ivalid_e", 32'(issueValid6), 32'b01);
        applyStimulus(1'b1, 1'b0, 2'b00, rdy(0), rdy(0), 2'b01, '0, 0);
        step();
        idle(1'b1);
        checkOutput("w6_drain", 32'(count6), 32'd0);

        // Asynchronous reset in the middle of operation
        applyStimulus(1'b0, 1'b0, 2'b11, rdy(33), rdy(34), 2'b00, '0, 0);
        step();
        idle(1'b0);
        checkOutput("pre_arst_count", 32'(count8), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_count", 32'(count8), 32'd0);
        checkOutput("arst_ivalid", 32'(issueValid8), 32'b00);
        checkOutput("arst_wrready", 32'(wrReady8), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("after_arst_count", 32'(count8), 32'd0);
        checkOutput("after_arst_ivalid", 32'(issueValid8), 32'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
